axi4_sram_slave: RTL

- AXI4 responder (slave) that terminates the shared master port driven by the IFU/LSU arbiter.
- Backs a word-organised on-chip SRAM model and serves single and burst reads and writes.
- Serialises transactions: one read or one write burst in flight at a time, matching the arbiter's single-owner bus.
- Used as main-memory stand-in for simulation and for early bring-up of the bus path.

---
 rtl/axi4_sram_slave.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_sram_slave.sv
// AXI4 responder backed by a word-organised SRAM model; serves one read or write burst at a time.
// Per-beat DECERR/SLVERR checks, byte-lane writes, programmable read latency.
module axi4_sram_slave #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h8000_0000,
   parameter int                    MEM_DEPTH    = 4096,
   parameter int                    READ_LATENCY = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [3:0]              awid,
   input  logic [7:0]              awlen,
   input  logic [2:0]              awsize,
   input  logic [1:0]              awburst,
   input  logic                    wvalid,
   output logic                    wready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wlast,
   output logic                    bvalid,
   input  logic                    bready,
   output logic [1:0]              bresp,
   output logic [3:0]              bid,
   input  logic                    arvalid,
   output logic                    arready,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic [3:0]              arid,
   input  logic [7:0]              arlen,
   input  logic [2:0]              arsize,
   input  logic [1:0]              arburst,
   output logic                    rvalid,
   input  logic                    rready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rlast,
   output logic [3:0]              rid,
   output logic [2:0]              dbg_state_o
);

   localparam int                  IDX_W    = $clog2(MEM_DEPTH);
   localparam logic [ADDR_WIDTH:0] END_ADDR = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * MEM_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_WAIT = 3'd1,
      S_RD_DATA = 3'd2,
      S_WR_DATA = 3'd3,
      S_WR_RESP = 3'd4
   } state_e;

   function automatic logic [1:0] beat_resp(input logic [ADDR_WIDTH-1:0] addr,
                                            input logic [2:0] size, input logic [1:0] burst);
      logic [1:0] resp;
      resp = 2'b00;
      if ({1'b0, addr} < {1'b0, BASE_ADDR} || {1'b0, addr} >= END_ADDR) resp = 2'b11;
      else if (size > 3'd2 || burst[1]) resp = 2'b10;
      return resp;
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
      return IDX_W'((addr - BASE_ADDR) >> 2);
   endfunction

   state_e                  state_q, state_d;
   logic [3:0]              id_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [7:0]              len_q, beat_q;
   logic [2:0]              size_q;
   logic [1:0]              burst_q;
   logic [3:0]              lat_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [1:0]              rresp_q, bresp_q;
   logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

   logic                    ar_hs, aw_hs, w_hs, r_hs, b_hs;
   logic                    last_beat, mem_we;
   logic [ADDR_WIDTH-1:0]   next_addr;
   logic [1:0]              cur_resp, nxt_resp, wr_resp;

   // A transfer happens on any rising edge where valid and ready are both high;
   // valid never waits on ready, and every ready/valid is forced low while reset is held.
   assign ar_hs     = arvalid && arready;
   assign aw_hs     = awvalid && awready;
   assign w_hs      = wvalid && wready;
   assign r_hs      = rvalid && rready;
   assign b_hs      = bvalid && bready;
   assign last_beat = (beat_q == len_q);
   assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + (ADDR_WIDTH'(1) << size_q);
   assign cur_resp  = beat_resp(addr_q, size_q, burst_q);
   assign nxt_resp  = beat_resp(next_addr, size_q, burst_q);
   assign mem_we    = (state_q == S_WR_DATA) && w_hs && (cur_resp == 2'b00);

   always_comb begin
      wr_resp = cur_resp;
      if ((wlast != last_beat) && (cur_resp == 2'b00)) wr_resp = 2'b10;
   end

   always_ff @(posedge clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (ar_hs)      state_d = S_RD_WAIT;
            else if (aw_hs) state_d = S_WR_DATA;
         end
         S_RD_WAIT: if (lat_q == 4'd0)       state_d = S_RD_DATA;
         S_RD_DATA: if (r_hs && last_beat)   state_d = S_IDLE;
         S_WR_DATA: if (w_hs && last_beat)   state_d = S_WR_RESP;
         S_WR_RESP: if (b_hs)                state_d = S_IDLE;
         default:                            state_d = S_IDLE;
      endcase
   end

   always_comb begin
      arready = 1'b0;
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      bresp   = 2'b00;
      bid     = 4'd0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rid     = 4'd0;
      case (state_q)
         S_IDLE: begin
            arready = !reset;
            awready = !reset && !arvalid;
         end
         S_RD_DATA: begin
            rvalid = !reset;
            rlast  = !reset && last_beat;
            rid    = id_q;
         end
         S_WR_DATA: wready = !reset;
         S_WR_RESP: begin
            bvalid = !reset;
            bresp  = bresp_q;
            bid    = id_q;
         end
         default: ;
      endcase
   end

   assign rdata       = rdata_q;
   assign rresp       = rresp_q;
   assign dbg_state_o = state_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         id_q    <= 4'd0;
         addr_q  <= '0;
         len_q   <= 8'd0;
         size_q  <= 3'd0;
         burst_q <= 2'b00;
         beat_q  <= 8'd0;
         lat_q   <= 4'd0;
         rdata_q <= '0;
         rresp_q <= 2'b00;
         bresp_q <= 2'b00;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ar_hs) begin
                  id_q    <= arid;
                  addr_q  <= araddr;
                  len_q   <= arlen;
                  size_q  <= arsize;
                  burst_q <= arburst;
                  beat_q  <= 8'd0;
                  lat_q   <= 4'(READ_LATENCY);
               end else if (aw_hs) begin
                  id_q    <= awid;
                  addr_q  <= awaddr;
                  len_q   <= awlen;
                  size_q  <= awsize;
                  burst_q <= awburst;
                  beat_q  <= 8'd0;
                  bresp_q <= 2'b00;
               end
            end
            S_RD_WAIT: begin
               if (lat_q != 4'd0) begin
                  lat_q <= lat_q - 4'd1;
               end else begin
                  rresp_q <= cur_resp;
                  rdata_q <= (cur_resp == 2'b00) ? mem_q[word_idx(addr_q)] : '0;
               end
            end
            S_RD_DATA: begin
               // Next beat is fetched on the handshake so it is presented with no bubble.
               if (r_hs && !last_beat) begin
                  addr_q  <= next_addr;
                  beat_q  <= beat_q + 8'd1;
                  rresp_q <= nxt_resp;
                  rdata_q <= (nxt_resp == 2'b00) ? mem_q[word_idx(next_addr)] : '0;
               end
            end
            S_WR_DATA: begin
               if (w_hs) begin
                  bresp_q <= (wr_resp > bresp_q) ? wr_resp : bresp_q;
                  if (!last_beat) begin
                     addr_q <= next_addr;
                     beat_q <= beat_q + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (wstrb[i]) mem_q[word_idx(addr_q)][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

endmodule
